// File: rtl/pmem_norm_if.sv
`default_nettype none
// ============================================================================
// pmem_norm_if : pmem read bus plus normalized-row valid/ready stream
// Revision 1.0
// ============================================================================
interface pmem_norm_if #(
   parameter int BW_PSUM = 12,
   parameter int COL     = 8,
   parameter int ADDR_W  = 4
);
   logic                     pmem_rd;
   logic [ADDR_W-1:0]        pmem_add;
   logic [BW_PSUM*COL-1:0]   pmem_out;
   logic [BW_PSUM*COL-1:0]   norm_out;
   logic                     norm_valid;
   logic                     norm_ready;
   logic [BW_PSUM+2:0]       sum_out;

   modport master (
      output pmem_rd, pmem_add, norm_out, norm_valid, sum_out,
      input  pmem_out, norm_ready
   );

   modport slave (
      input  pmem_rd, pmem_add, norm_out, norm_valid, sum_out,
      output pmem_out, norm_ready
   );
endinterface
`default_nettype wire

// File: rtl/pmem_norm_reader.sv
`default_nettype none
// ============================================================================
// pmem_norm_reader : reads psum rows from pmem, emits (|x| << FRAC) / sum(|x|)
// Revision 1.0
// ============================================================================
module pmem_norm_reader #(
   parameter int BW_PSUM = 12,
   parameter int COL     = 8,
   parameter int ADDR_W  = 4,
   parameter int FRAC    = 12
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              start,
   input  wire logic [ADDR_W:0]   num_rows,
   input  wire logic              sign_mode,
   output      logic              busy,
   output      logic              done,
   pmem_norm_if.master            bus
);

   localparam int c_DIV_BITS = BW_PSUM + FRAC;
   localparam int c_SUM_W    = BW_PSUM + 3;
   localparam int c_CNT_W    = $clog2(c_DIV_BITS);
   localparam int c_ELEM_W   = (COL > 1) ? $clog2(COL) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_CAP, S_SUM, S_DIV, S_OUT, S_FIN
   } state_t;

   state_t                    r_state, w_next;
   logic [ADDR_W:0]           r_num_rows, r_row;
   logic                      r_sign, r_done;
   logic [BW_PSUM*COL-1:0]    r_buf, r_norm;
   logic [c_SUM_W-1:0]        r_sum, r_rem, w_abs_sum, w_rem_nx;
   logic [c_SUM_W:0]          w_rem_sh;
   logic [c_DIV_BITS-1:0]     r_dvd;
   logic [BW_PSUM-2:0]        r_quot;
   logic [BW_PSUM-1:0]        w_quot_nx;
   logic [c_CNT_W-1:0]        r_bit;
   logic [c_ELEM_W-1:0]       r_elem, w_nxt_elem;
   logic                      w_q_bit, w_last_bit, w_last_elem, w_last_row;
   logic [BW_PSUM-1:0]        w_abs [COL];

   // Negating the most negative value wraps to itself, which read unsigned is 2^(BW_PSUM-1)
   for (genvar q = 0; q < COL; q++) begin : g_abs
      assign w_abs[q] = (r_sign && r_buf[BW_PSUM*(q+1)-1])
                        ? (~r_buf[BW_PSUM*q +: BW_PSUM] + 1'b1)
                        : r_buf[BW_PSUM*q +: BW_PSUM];
   end

   always_comb begin
      w_abs_sum = '0;
      for (int q = 0; q < COL; q++) begin
         w_abs_sum = w_abs_sum + c_SUM_W'(w_abs[q]);
      end
   end

   // Restoring step; a zero divisor suppresses every quotient bit
   assign w_rem_sh    = {r_rem, r_dvd[c_DIV_BITS-1]};
   assign w_q_bit     = (r_sum != '0) && (w_rem_sh >= {1'b0, r_sum});
   assign w_rem_nx    = w_q_bit ? c_SUM_W'(w_rem_sh - {1'b0, r_sum}) : w_rem_sh[c_SUM_W-1:0];
   assign w_quot_nx   = {r_quot, w_q_bit};
   assign w_last_bit  = (r_bit == c_CNT_W'(c_DIV_BITS - 1));
   assign w_last_elem = (r_elem == c_ELEM_W'(COL - 1));
   assign w_last_row  = (r_row == r_num_rows - 1'b1);
   assign w_nxt_elem  = r_elem + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (start) w_next = (num_rows != '0) ? S_RD : S_FIN;
         S_RD:   w_next = S_CAP;
         S_CAP:  w_next = S_SUM;
         S_SUM:  w_next = S_DIV;
         S_DIV:  if (w_last_bit && w_last_elem) w_next = S_OUT;
         S_OUT:  if (bus.norm_ready) w_next = w_last_row ? S_FIN : S_RD;
         S_FIN:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_num_rows <= '0;
         r_row      <= '0;
         r_sign     <= 1'b0;
         r_done     <= 1'b0;
         r_buf      <= '0;
         r_norm     <= '0;
         r_sum      <= '0;
         r_rem      <= '0;
         r_dvd      <= '0;
         r_quot     <= '0;
         r_bit      <= '0;
         r_elem     <= '0;
      end else begin
         r_done <= (r_state == S_FIN);
         case (r_state)
            S_IDLE: if (start) begin
               r_num_rows <= num_rows;
               r_sign     <= sign_mode;
               r_row      <= '0;
            end
            S_CAP: r_buf <= bus.pmem_out;
            S_SUM: begin
               r_sum  <= w_abs_sum;
               r_elem <= '0;
               r_bit  <= '0;
               r_rem  <= '0;
               r_quot <= '0;
               r_dvd  <= {w_abs[0], {FRAC{1'b0}}};
            end
            S_DIV: begin
               r_rem  <= w_rem_nx;
               r_quot <= w_quot_nx[BW_PSUM-2:0];
               r_dvd  <= r_dvd << 1;
               r_bit  <= r_bit + 1'b1;
               if (w_last_bit) begin
                  r_norm[r_elem*BW_PSUM +: BW_PSUM] <= w_quot_nx;
                  r_bit  <= '0;
                  r_rem  <= '0;
                  r_quot <= '0;
                  if (!w_last_elem) begin
                     r_elem <= w_nxt_elem;
                     r_dvd  <= {w_abs[w_nxt_elem], {FRAC{1'b0}}};
                  end
               end
            end
            S_OUT: if (bus.norm_ready && !w_last_row) r_row <= r_row + 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.pmem_rd    = (r_state == S_RD);
   assign bus.pmem_add   = r_row[ADDR_W-1:0];
   assign bus.norm_out   = r_norm;
   assign bus.norm_valid = (r_state == S_OUT);
   assign bus.sum_out    = r_sum;
   assign busy           = (r_state != S_IDLE) && (r_state != S_FIN);
   assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pmem_norm_reader.sv
`default_nettype none
// ============================================================================
// tb_pmem_norm_reader : randomized rows checked against an arithmetic model
// Revision 1.0
// ============================================================================
module tb_pmem_norm_reader;
   localparam int BW   = 12;
   localparam int COL  = 8;
   localparam int AW   = 4;
   localparam int FRAC = 12;
   localparam int LAT  = 3 + COL * (BW + FRAC);

   logic          clk = 1'b0;
   logic          reset, start, sign_mode, busy, done;
   logic [AW:0]   num_rows;

   pmem_norm_if #(.BW_PSUM(BW), .COL(COL), .ADDR_W(AW)) bus ();

   pmem_norm_reader #(.BW_PSUM(BW), .COL(COL), .ADDR_W(AW), .FRAC(FRAC)) dut (
      .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
      .sign_mode(sign_mode), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [BW*COL-1:0] mem [16];
   always @(posedge clk) if (bus.pmem_rd) bus.pmem_out <= mem[bus.pmem_add];

   int rd_cyc[$];
   int rd_add[$];
   always @(negedge clk) if (bus.pmem_rd) begin
      rd_cyc.push_back(cyc);
      rd_add.push_back(int'(bus.pmem_add));
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [BW*COL-1:0] ref_row(input logic [BW*COL-1:0] row, input bit sm,
                                                 output int s);
      int a [COL];
      logic [BW*COL-1:0] res;
      s = 0;
      for (int q = 0; q < COL; q++) begin
         int x;
         x = int'(row[q*BW +: BW]);
         if (sm && x >= (1 << (BW-1))) x -= (1 << BW);
         a[q] = (x < 0) ? -x : x;
         s += a[q];
      end
      for (int q = 0; q < COL; q++)
         res[q*BW +: BW] = (s == 0) ? '0 : BW'((a[q] << FRAC) / s);
      return res;
   endfunction

   function automatic logic [BW*COL-1:0] rand_row();
      logic [BW*COL-1:0] row;
      for (int q = 0; q < COL; q++)
         row[q*BW +: BW] = ($urandom_range(0, 1) == 1) ? BW'($urandom) : BW'($urandom_range(0, 7));
      return row;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 16; i++) mem[i] = rand_row();
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_rd"},    bus.pmem_rd, 0);
      check({tag, "_add"},   bus.pmem_add, 0);
      check({tag, "_norm"},  bus.norm_out, 0);
      check({tag, "_valid"}, bus.norm_valid, 0);
      check({tag, "_sum"},   bus.sum_out, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
   endtask

   task automatic start_job(input int n, input bit sm);
      rd_cyc.delete();
      rd_add.delete();
      num_rows  = (AW+1)'(n);
      sign_mode = sm;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      check("busy_after_start", busy, (n > 0) ? 1 : 0);
   endtask

   // Consumes rows in order; abort_row leaves the job sitting mid-division
   task automatic run_rows(input int n, input bit sm, input int stall_row,
                           input int stall_len, input int abort_row);
      logic [BW*COL-1:0] exp;
      int s, acc, guard;
      acc = 0;
      for (int r = 0; r < n; r++) begin
         if (r == abort_row) begin
            repeat (50) @(negedge clk);
            return;
         end
         guard = 0;
         while (!bus.norm_valid && guard < 400) begin
            @(negedge clk);
            guard++;
         end
         check("valid_timeout", bus.norm_valid, 1);
         if (!bus.norm_valid) return;
         exp = ref_row(mem[r], sm, s);
         check("norm_out", bus.norm_out, exp);
         check("sum_out", bus.sum_out, s);
         check("rd_count", rd_cyc.size(), r + 1);
         if (rd_cyc.size() == r + 1) begin
            check("rd_addr", rd_add[r], r);
            check("latency", cyc - rd_cyc[r], LAT);
         end
         if (r == stall_row) begin
            for (int k = 0; k < stall_len; k++) begin
               @(negedge clk);
               check("stall_valid", bus.norm_valid, 1);
               check("stall_norm", bus.norm_out, exp);
               check("stall_sum", bus.sum_out, s);
               check("stall_no_rd", rd_cyc.size(), r + 1);
            end
         end
         bus.norm_ready = 1'b1;
         acc = cyc;
         @(negedge clk);
         bus.norm_ready = 1'b0;
         check("valid_drop", bus.norm_valid, 0);
      end
      guard = 0;
      while (!done && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      check("done_delay", cyc - acc, 2);
      check("done_busy", busy, 0);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("total_reads", rd_cyc.size(), n);
   endtask

   initial begin
      int n, quiet, dcount;
      bit sm;
      reset = 1'b1; start = 1'b0; num_rows = '0; sign_mode = 1'b0;
      bus.norm_ready = 1'b0;
      fill_random();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_outs("reset");

      // unit row: every element 1 -> S=8, each slot 0x200
      mem[0] = {COL{12'h001}};
      start_job(1, 1'b0);
      run_rows(1, 1'b0, -1, 0, -1);

      // signed rows, including the most negative value
      mem[0] = {{6{12'h000}}, 12'h001, 12'hFFD};
      mem[1] = {{7{12'h000}}, 12'h005};
      mem[2] = {{4{12'h000}}, 12'h001, 12'hFFF, 12'h7FF, 12'h800};
      start_job(3, 1'b1);
      run_rows(3, 1'b1, -1, 0, -1);

      // all-zero row: zero sum, same latency
      mem[0] = '0;
      start_job(1, 1'b1);
      run_rows(1, 1'b1, -1, 0, -1);

      // eight rows with a consumer stall on row 3
      fill_random();
      sm = 1'($urandom_range(0, 1));
      start_job(8, sm);
      run_rows(8, sm, 3, 5, -1);

      // zero-row job: only a done pulse
      start_job(0, 1'b0);
      dcount = 0;
      repeat (6) begin
         if (done) dcount++;
         @(negedge clk);
      end
      check("zero_done_count", dcount, 1);
      check("zero_no_rd", rd_cyc.size(), 0);

      // start while busy must not change the latched row count
      fill_random();
      start_job(2, 1'b0);
      repeat (3) @(negedge clk);
      num_rows = 5'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_rows(2, 1'b0, -1, 0, -1);
      quiet = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.norm_valid || bus.pmem_rd) quiet++;
      end
      check("busy_start_quiet", quiet, 0);

      // reset in the middle of row 2's division
      fill_random();
      start_job(4, 1'b0);
      run_rows(4, 1'b0, -1, 0, 2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_outs("midreset");
      rd_cyc.delete();
      quiet = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus.norm_valid || bus.pmem_rd || done) quiet++;
      end
      check("midreset_quiet", quiet, 0);
      start_job(2, 1'b0);
      run_rows(2, 1'b0, -1, 0, -1);

      // random jobs with random stalls
      for (int j = 0; j < 3; j++) begin
         int sr;
         fill_random();
         n  = $urandom_range(1, 4);
         sm = 1'($urandom_range(0, 1));
         sr = $urandom_range(0, n - 1);
         start_job(n, sm);
         run_rows(n, sm, sr, $urandom_range(0, 4), -1);
      end

      // full address range
      fill_random();
      sm = 1'($urandom_range(0, 1));
      start_job(16, sm);
      run_rows(16, sm, $urandom_range(0, 15), 2, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire

// File: doc/pmem_norm_reader.md
Name: pmem_norm_reader

Overview:
- Read-side consumer of the per-core psum memory (pmem).
- After the host has moved ofifo contents into pmem, this block issues pmem_rd/pmem_add, captures each psum row, and forms the absolute-value row sum.
- Each element is normalized as (|x| << 12) / sum.
- Normalized rows stream out over a valid/ready handshake. One instance sits per core, beside pmem.

Parameters:
bw_psum, 12, width of one psum element and of one normalized element
col, 8, elements per pmem row
addr_w, 4, pmem address width
frac, 12, left shift applied to |x| before division

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a readout of num_rows rows from address 0 (ignored unless idle)
num_rows  input  addr_w+1  row count, sampled on start
sign_mode  input  1  1: psum elements are two's complement; 0: unsigned; sampled on start
pmem_rd  output  1  pmem read enable
pmem_add  output  addr_w  pmem read address
pmem_out  input  bw_psum*col  pmem read data, valid the cycle after pmem_rd
norm_out  output  bw_psum*col  normalized row; element q at bits [bw_psum*(q+1)-1 : bw_psum*q]
norm_valid  output  1  norm_out holds a complete row
norm_ready  input  1  consumer accepts the row when norm_valid && norm_ready
sum_out  output  bw_psum+3  abs sum of the row currently on norm_out
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset values: pmem_rd=0, pmem_add=0, norm_out=0, norm_valid=0, sum_out=0, busy=0, done=0, FSM=IDLE.
- Reset is honoured in any state, including mid-division or while norm_valid is high. No output is emitted afterward.

FSM states: IDLE, RD, CAP, SUM, DIV, OUT, FIN.

- IDLE:
  - start with num_rows>0: latch num_rows and sign_mode, row counter r=0, go to RD.
  - start with num_rows=0: go to FIN.
- RD: pmem_rd=1 and pmem_add=r for exactly one cycle; go to CAP.
- CAP: register pmem_out into the row buffer; pmem_rd=0; go to SUM.
- SUM (one cycle):
  - a_q = |x_q|. In sign_mode, elements are sign-extended. -2^(bw_psum-1) yields magnitude 2^(bw_psum-1).
  - S = sum of a_q, width bw_psum+3, never overflows. Element index e=0. Go to DIV.
- DIV: radix-2 restoring divider, one quotient bit per cycle, bw_psum+frac cycles per element.
  - Dividend = a_e << frac; divisor = S.
  - Quotient is truncated to its low bw_psum bits (wraps; matches the golden model) and written to slot e.
  - S=0 forces quotient 0, with the same cycle count.
  - After e=col-1, go to OUT.
- OUT: norm_valid=1; norm_out and sum_out are held stable until handshake.
  - On norm_valid && norm_ready, norm_valid drops the next cycle.
  - r==num_rows-1: go to FIN. Otherwise r=r+1 and go to RD.
  - No pmem read is issued while a row is waiting in OUT.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- start while busy is ignored, with no effect on the latched num_rows.
- pmem_add counts 0..num_rows-1. num_rows=2^addr_w reads every address, and the counter does not wrap early.
- Row latency from pmem_rd to norm_valid: 3 + col*(bw_psum+frac) cycles (195 at defaults).
- Rows are emitted strictly in address order.

Test Plan:
1. Unsigned, num_rows=1, row all 1 -> S=8, every element 4096/8=0x200. norm_out=0x200 repeated 8×, sum_out=8, norm_valid 195 cycles after pmem_rd, done pulse 2 cycles after accept.
2. sign_mode=1, row {x0=-3 (0xFFD), x1=1, rest 0} -> S=4, elem0=0xC00, elem1=0x400, others 0. Also one row {x0=5, rest 0} -> S=5, 4096/5... no: 5·4096/5=4096, truncated to 0x000.
3. All-zero row -> S=0, norm_out all 0, sum_out=0, cycle count identical to case 1.
4. num_rows=8 with norm_ready held low 5 cycles on row 3 -> norm_out/sum_out stable, no pmem_rd during the stall. pmem_add sequence is 0..7, one read per row, 8 accepted rows in order.
5. Reset asserted during DIV of row 2 -> all outputs return to reset values next cycle. A new start then reads from address 0 again.
6. start with num_rows=0 -> no pmem_rd, done pulses exactly once. start while busy -> ignored, row count unchanged.
